mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 10, word-address width of the shared 1024-word memory.
REQ-002 The module SHALL have parameter DW, default 32, data width.
REQ-003 The module SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive data grants while if_req is pending.
REQ-004 Ports SHALL be, in order:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  instruction-fetch read request, level
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch access issued this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data-memory request, level
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data access issued this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0
- busy  out  1  state is not IDLE

Function
REQ-005 The FSM SHALL have three states: IDLE, ACC, RESP.
REQ-006 Arbitration SHALL occur in IDLE and RESP. If any request is high, the FSM SHALL go to ACC and register the winner, address, we and wdata; otherwise it SHALL go to IDLE.
REQ-007 In ACC the block SHALL drive mem_en=1, mem_addr/mem_we/mem_wdata from the registered values, and the winner's gnt=1 for exactly one cycle; the next state SHALL be RESP.
REQ-008 In RESP after a read, the block SHALL assert the winner's rvalid for one cycle with rdata = mem_rdata. After a write, rvalid SHALL remain 0.
REQ-009 Latency: a request sampled at edge N SHALL produce gnt/mem_en in cycle N+1 and rvalid in cycle N+2.
REQ-010 Sustained throughput SHALL be one access per two cycles, with back-to-back accesses running RESP to ACC without returning to IDLE.
REQ-011 A requester SHALL hold req high until it sees its gnt. A req still high in the cycle after gnt SHALL be treated as a new request.
REQ-012 Default priority: dm wins over if when both requests are high.
REQ-013 Starvation guard: a 3-bit counter SHALL increment on each dm grant made while if_req is high, and clear on any if grant. When the counter reaches STARVE_MAX, if SHALL win the next contested arbitration.
REQ-014 if_rdata and dm_rdata SHALL hold their last value when rvalid is low. The mem_* outputs SHALL be 0 when mem_en is low.
REQ-015 A write to an address followed by a read of the same address SHALL return the new data, because the accesses are serialized.
REQ-016 A request that drops before being sampled SHALL be ignored, with no gnt and no memory access.

Reset
REQ-017 Asserting rst at any time SHALL asynchronously force: state=IDLE, every gnt/rvalid/mem_en/mem_we/busy=0, mem_addr/mem_wdata/rdata=0, starvation counter=0, last-winner flag=if.
REQ-018 Reset asserted during ACC or RESP SHALL abort the access with no rvalid. The requester SHALL re-request.
REQ-019 The first arbitration SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-020 When macro ARB_RR_EN is defined, contested arbitrations SHALL use round-robin: the loser of the previous contested grant wins, and the starvation counter SHALL be removed.
REQ-021 When ARB_RR_EN is undefined, arbitration SHALL be fixed dm priority plus the starvation guard of REQ-013.

Verification
REQ-022 Single fetch: preload mem[5]=0xDEADBEEF, pulse if_req with if_addr=5 -> if_gnt at +1, if_rvalid and if_rdata=0xDEADBEEF at +2, dm_* outputs idle.
REQ-023 Store then load: dm store 0x12345678 to address 7, then load address 7 -> dm_rvalid with dm_rdata=0x12345678, and no dm_rvalid for the store.
REQ-024 Contention, macro off: both requests held continuously -> grant order dm,dm,dm,dm,if, repeating, with accesses spaced every 2 cycles.
REQ-025 Contention, ARB_RR_EN on: both requests held -> grants alternate if,dm,if,dm starting from reset.
REQ-026 Reset mid-access: assert rst during ACC of a read -> all outputs 0 immediately, no rvalid afterward, and a fresh request after release completes normally.
REQ-027 Idle check: no requests for 20 cycles -> mem_en=0 and busy=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-ported synchronous memory. One access every two cycles (ACC, RESP).
// Optional feature macro: ARB_RR_EN selects round-robin contested arbitration
// instead of fixed data priority with a starvation guard.
module mem_port_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e        state_q, state_d;
    logic          win_dm_q, win_dm_d;   // 1: current access belongs to dm
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          pick_dm;
    logic          resp_rd;

`ifdef ARB_RR_EN
    // Side that wins the next contested arbitration; if goes first out of reset.
    logic rr_dm_q, rr_dm_d;
`else
    localparam logic [2:0] StarveMax = 3'(STARVE_MAX);
    logic [2:0] cnt_q, cnt_d;
`endif

    // Winner selection for an arbitration slot
    always_comb begin
        pick_dm = dm_req;
        if (if_req && dm_req) begin
`ifdef ARB_RR_EN
            pick_dm = rr_dm_q;
`else
            pick_dm = (cnt_q < StarveMax);
`endif
        end
    end

    // Next-state: arbitrate in IDLE/RESP, capture read data in RESP
    always_comb begin
        state_d    = state_q;
        win_dm_d   = win_dm_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef ARB_RR_EN
        rr_dm_d    = rr_dm_q;
`else
        cnt_d      = cnt_q;
`endif
        if (state_q == StResp && !we_q) begin
            if (win_dm_q) dm_rdata_d = mem_rdata;
            else          if_rdata_d = mem_rdata;
        end
        unique case (state_q)
            StAcc: state_d = StResp;
            default: begin
                if (if_req || dm_req) begin
                    state_d  = StAcc;
                    win_dm_d = pick_dm;
                    addr_d   = pick_dm ? dm_addr : if_addr;
                    we_d     = pick_dm & dm_we;
                    wdata_d  = pick_dm ? dm_wdata : '0;
`ifdef ARB_RR_EN
                    if (if_req && dm_req) rr_dm_d = ~pick_dm;
`else
                    if (!pick_dm)                    cnt_d = '0;
                    else if (if_req && cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            win_dm_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef ARB_RR_EN
            rr_dm_q    <= 1'b0;
`else
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            win_dm_q   <= win_dm_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef ARB_RR_EN
            rr_dm_q    <= rr_dm_d;
`else
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Outputs decoded from state; read data passes through during its valid cycle
    always_comb begin
        resp_rd   = (state_q == StResp) && !we_q;
        mem_en    = (state_q == StAcc);
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? addr_q : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        if_gnt    = mem_en & ~win_dm_q;
        dm_gnt    = mem_en & win_dm_q;
        if_rvalid = resp_rd & ~win_dm_q;
        dm_rvalid = resp_rd & win_dm_q;
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus directed
// sequences for reset, dropped requests, idle and contention.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [9:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous 1024-word memory, one-cycle read latency
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (rst) mem[5] <= 32'hDEADBEEF;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " if_gnt"}, 64'(if_gnt), 64'd0);
        check({tag, " dm_gnt"}, 64'(dm_gnt), 64'd0);
        check({tag, " if_rvalid"}, 64'(if_rvalid), 64'd0);
        check({tag, " dm_rvalid"}, 64'(dm_rvalid), 64'd0);
        check({tag, " mem_en"}, 64'(mem_en), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, " if_rdata"}, 64'(if_rdata), 64'd0);
        check({tag, " dm_rdata"}, 64'(dm_rdata), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    endtask

    typedef struct {
        logic        ifq;  logic [9:0] ia;
        logic        dq;   logic       dwe; logic [9:0] da; logic [31:0] dwd;
        logic        eig;  logic       eiv; logic [31:0] eird;
        logic        edg;  logic       edv; logic [31:0] edrd;
        logic        een;  logic       ewe; logic [9:0] ea; logic [31:0] ewd;
        logic        eb;
    } vec_t;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] SD = 32'h12345678;

    vec_t vecs [16];
    int   gw [10];
    int   gc [10];
    int   n_g;

    initial begin
        // Single fetch of address 5
        vecs[0]  = '{1, 5, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0,   1, 0, 0,  0, 0, 0,   1, 0, 5, 0,  1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0,   0, 1, DB, 0, 0, 0,   0, 0, 0, 0,  1};
        vecs[3]  = '{0, 0, 0, 0, 0, 0,   0, 0, DB, 0, 0, 0,   0, 0, 0, 0,  0};
        // Store to 7, then load 7 requested from RESP (back-to-back)
        vecs[4]  = '{0, 0, 1, 1, 7, SD,  0, 0, DB, 0, 0, 0,   0, 0, 0, 0,  0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0,   0, 0, DB, 1, 0, 0,   1, 1, 7, SD, 1};
        vecs[6]  = '{0, 0, 1, 0, 7, 0,   0, 0, DB, 0, 0, 0,   0, 0, 0, 0,  1};
        vecs[7]  = '{0, 0, 0, 0, 0, 0,   0, 0, DB, 1, 0, 0,   1, 0, 7, 0,  1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0,   0, 0, DB, 0, 1, SD,  0, 0, 0, 0,  1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0,   0, 0, DB, 0, 0, SD,  0, 0, 0, 0,  0};
        // Fetch req held through RESP counts as a second request
        vecs[10] = '{1, 5, 0, 0, 0, 0,   0, 0, DB, 0, 0, SD,  0, 0, 0, 0,  0};
        vecs[11] = '{1, 5, 0, 0, 0, 0,   1, 0, DB, 0, 0, SD,  1, 0, 5, 0,  1};
        vecs[12] = '{1, 5, 0, 0, 0, 0,   0, 1, DB, 0, 0, SD,  0, 0, 0, 0,  1};
        vecs[13] = '{0, 0, 0, 0, 0, 0,   1, 0, DB, 0, 0, SD,  1, 0, 5, 0,  1};
        vecs[14] = '{0, 0, 0, 0, 0, 0,   0, 1, DB, 0, 0, SD,  0, 0, 0, 0,  1};
        vecs[15] = '{0, 0, 0, 0, 0, 0,   0, 0, DB, 0, 0, SD,  0, 0, 0, 0,  0};

        idle_inputs();
        rst = 1;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].ifq; if_addr = vecs[i].ia;
            dm_req = vecs[i].dq; dm_we = vecs[i].dwe; dm_addr = vecs[i].da;
            dm_wdata = vecs[i].dwd;
            @(negedge clk);
            check($sformatf("v%0d if_gnt", i), 64'(if_gnt), 64'(vecs[i].eig));
            check($sformatf("v%0d if_rvalid", i), 64'(if_rvalid), 64'(vecs[i].eiv));
            check($sformatf("v%0d if_rdata", i), 64'(if_rdata), 64'(vecs[i].eird));
            check($sformatf("v%0d dm_gnt", i), 64'(dm_gnt), 64'(vecs[i].edg));
            check($sformatf("v%0d dm_rvalid", i), 64'(dm_rvalid), 64'(vecs[i].edv));
            check($sformatf("v%0d dm_rdata", i), 64'(dm_rdata), 64'(vecs[i].edrd));
            check($sformatf("v%0d mem_en", i), 64'(mem_en), 64'(vecs[i].een));
            check($sformatf("v%0d mem_we", i), 64'(mem_we), 64'(vecs[i].ewe));
            check($sformatf("v%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].ea));
            check($sformatf("v%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].ewd));
            check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].eb));
        end

        // Request that drops before any edge samples it
        @(posedge clk); #1;
        if_req = 1; if_addr = 10'd5;
        #2 if_req = 0;
        @(posedge clk); #1;
        check("drop if_gnt", 64'(if_gnt), 64'd0);
        check("drop mem_en", 64'(mem_en), 64'd0);
        check("drop busy", 64'(busy), 64'd0);

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d mem_en", i), 64'(mem_en), 64'd0);
            check($sformatf("idle%0d busy", i), 64'(busy), 64'd0);
        end

        // Reset during ACC of a fetch
        @(posedge clk); #1;
        if_req = 1; if_addr = 10'd5;
        @(posedge clk); #1;
        if_req = 0;
        check("rstacc if_gnt", 64'(if_gnt), 64'd1);
        #1 rst = 1;
        #1 check_zero("rstacc");
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("postrst%0d if_rvalid", i), 64'(if_rvalid), 64'd0);
            check($sformatf("postrst%0d busy", i), 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        if_req = 1;
        @(posedge clk); #1;
        if_req = 0;
        check("refetch if_gnt", 64'(if_gnt), 64'd1);
        check("refetch mem_addr", 64'(mem_addr), 64'd5);
        @(posedge clk); #1;
        check("refetch if_rvalid", 64'(if_rvalid), 64'd1);
        check("refetch if_rdata", 64'(if_rdata), 64'(DB));

        // Contention from a fresh reset: both requests held
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        if_req = 1; if_addr = 10'd5;
        dm_req = 1; dm_we = 1; dm_addr = 10'd9; dm_wdata = 32'h1;
        n_g = 0;
        for (int cyc = 0; cyc < 60 && n_g < 10; cyc++) begin
            @(negedge clk);
            if (if_gnt || dm_gnt) begin
                gw[n_g] = (if_gnt && dm_gnt) ? 2 : (dm_gnt ? 1 : 0);
                gc[n_g] = cyc;
                n_g++;
            end
        end
        idle_inputs();
        check("contend grant count", 64'(n_g), 64'd10);
        for (int i = 0; i < n_g; i++) begin
`ifdef ARB_RR_EN
            check($sformatf("contend%0d winner", i), 64'(gw[i]), (i % 2 == 0) ? 64'd0 : 64'd1);
`else
            check($sformatf("contend%0d winner", i), 64'(gw[i]), (i % 5 == 4) ? 64'd0 : 64'd1);
`endif
            if (i > 0) check($sformatf("contend%0d spacing", i), 64'(gc[i] - gc[i-1]), 64'd2);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
